// File: rtl/rtc_read_sweep.sv
// Periodic read sweep of the nine RTC time/timer registers over the RTC bus.
// Captured values are held as BCD bytes; hour registers are masked per 12/24 h mode.
module rtc_read_sweep #(
    parameter int unsigned REFRESH_CYCLES = 100_000,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  ADDR_TIME      = 8'h21,
    parameter logic [7:0]  ADDR_TMR       = 8'h41
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_active,
    input  logic       SF_24_12,
    input  logic       rd_ack,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic [7:0] seg_t,
    output logic [7:0] min_t,
    output logic [7:0] hora_t,
    output logic       SF_AM_PM,
    output logic       sweep_done,
    output logic       rd_err,
    output logic [2:0] fsm_state
);
    localparam int unsigned TICK_W = $clog2(REFRESH_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        LAST_IDX  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [3:0]        index;
    logic              tick;
    logic              start;
    logic              capture;
    logic              timeout;
    logic [7:0]        addr;
    logic [7:0]        hour_val;

    assign tick       = (tick_cnt == TICK_LAST);
    assign fsm_state  = state;
    assign sweep_done = (state == S_DONE);

    // Handshake: rd_req is held with a stable rd_addr until the cycle in which rd_ack
    // is sampled high (rd_data valid in that same cycle) or the timeout expires.
    always_comb begin
        addr = ADDR_TIME + {4'b0000, index};
        if (index >= 4'd6) begin
            addr = ADDR_TMR + {4'b0000, index - 4'd6};
        end
    end

    always_comb begin
        hour_val = {2'b00, rd_data[5:0]};
        if (SF_24_12) begin
            hour_val = {3'b000, rd_data[4:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && !prog_active) begin
                    start      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // An ack on the final allowed cycle still counts as a good read.
                if (rd_ack) begin
                    capture    = 1'b1;
                    state_next = S_NEXT;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (index == LAST_IDX) begin
                    state_next = S_DONE;
                end else if (prog_active) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_req  <= 1'b0;
            rd_addr <= 8'h00;
            tmo_cnt <= '0;
            index   <= 4'd0;
            rd_err  <= 1'b0;
        end else begin
            if (state == S_REQ) begin
                rd_req  <= 1'b1;
                rd_addr <= addr;
                tmo_cnt <= '0;
            end else if (capture || timeout) begin
                rd_req <= 1'b0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (start) begin
                rd_err <= 1'b0;
            end else if (timeout) begin
                rd_err <= 1'b1;
            end

            if (start || state == S_DONE) begin
                index <= 4'd0;
            end else if (state == S_NEXT && index != LAST_IDX) begin
                index <= prog_active ? 4'd0 : index + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg      <= 8'h00;
            min      <= 8'h00;
            hora     <= 8'h00;
            day      <= 8'h00;
            month    <= 8'h00;
            year     <= 8'h00;
            seg_t    <= 8'h00;
            min_t    <= 8'h00;
            hora_t   <= 8'h00;
            SF_AM_PM <= 1'b0;
        end else if (capture) begin
            case (index)
                4'd0: seg   <= rd_data;
                4'd1: min   <= rd_data;
                4'd2: begin
                    hora     <= hour_val;
                    SF_AM_PM <= SF_24_12 & rd_data[5];
                end
                4'd3: day    <= rd_data;
                4'd4: month  <= rd_data;
                4'd5: year   <= rd_data;
                4'd6: seg_t  <= rd_data;
                4'd7: min_t  <= rd_data;
                4'd8: hora_t <= hour_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rtc_read_sweep.sv
// Bench for rtc_read_sweep: acts as the RTC slave and keeps a register-level model
// of what each captured byte must be, checked every cycle.
module tb_rtc_read_sweep;
    localparam int R      = 16;
    localparam int T      = 8;
    localparam int BUDGET = 4 * R + 2 * T + 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       prog_active = 1'b0;
    logic       SF_24_12 = 1'b0;
    logic       rd_ack = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] seg, min, hora, day, month, year, seg_t, min_t, hora_t;
    logic       SF_AM_PM;
    logic       sweep_done;
    logic       rd_err;
    logic [2:0] fsm_state;

    rtc_read_sweep #(
        .REFRESH_CYCLES(R),
        .TIMEOUT_CYCLES(T),
        .ADDR_TIME(8'h21),
        .ADDR_TMR(8'h41)
    ) dut (
        .clk(clk), .reset(reset), .prog_active(prog_active), .SF_24_12(SF_24_12),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_req(rd_req), .rd_addr(rd_addr),
        .seg(seg), .min(min), .hora(hora), .day(day), .month(month), .year(year),
        .seg_t(seg_t), .min_t(min_t), .hora_t(hora_t), .SF_AM_PM(SF_AM_PM),
        .sweep_done(sweep_done), .rd_err(rd_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    bit         cmp_en = 1'b0;
    bit         err_valid = 1'b0;
    logic [7:0] exp_reg [9];
    logic       exp_ampm = 1'b0;
    logic       exp_err = 1'b0;
    int         sw_lat [9];
    logic [7:0] sw_data [9];
    logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    string      names [9] = '{"seg", "min", "hora", "day", "month", "year", "seg_t", "min_t", "hora_t"};

    task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [7:0] dut_val(input int i);
        case (i)
            0: return seg;
            1: return min;
            2: return hora;
            3: return day;
            4: return month;
            5: return year;
            6: return seg_t;
            7: return min_t;
            default: return hora_t;
        endcase
    endfunction

    // Hour bytes keep 5 bits in 12 h mode (bit 5 is the PM flag) and 6 bits in 24 h mode.
    task automatic model_capture(input int idx, input logic [7:0] data);
        if (idx == 2 || idx == 8) begin
            exp_reg[idx] = SF_24_12 ? 8'(data % 32) : 8'(data % 64);
            if (idx == 2) exp_ampm = SF_24_12 ? logic'((data / 32) % 2) : 1'b0;
        end else begin
            exp_reg[idx] = data;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) exp_reg[i] = 8'h00;
        exp_ampm  = 1'b0;
        exp_err   = 1'b0;
        err_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && sweep_done) done_cnt++;
    end

    always @(negedge clk) begin
        if (reset && cmp_en) begin
            for (int i = 0; i < 9; i++) chk(dut_val(i) == exp_reg[i], names[i], 32'(dut_val(i)), 32'(exp_reg[i]));
            chk(SF_AM_PM == exp_ampm, "am_pm", 32'(SF_AM_PM), 32'(exp_ampm));
            if (err_valid) chk(rd_err == exp_err, "rd_err", 32'(rd_err), 32'(exp_err));
        end
    end

    // Serve one read; lat >= 0 acks on that WAIT cycle, lat < 0 withholds the ack.
    task automatic serve_read(input int idx, input int lat, input logic [7:0] data, input bit raise_prog);
        int n = 0;
        int hi;
        while (!rd_req && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk(rd_req == 1'b1, "req_arrive", 32'(rd_req), 32'd1);
        if (!rd_req) return;
        if (raise_prog) prog_active = 1'b1;
        if (idx == 0) begin
            chk(rd_err == 1'b0, "err_clear", 32'(rd_err), 32'd0);
            exp_err   = 1'b0;
            err_valid = 1'b1;
        end
        chk(rd_addr == addr_tab[idx], "rd_addr", 32'(rd_addr), 32'(addr_tab[idx]));
        if (lat >= 0) begin
            repeat (lat) @(negedge clk);
            chk(rd_req == 1'b1 && rd_addr == addr_tab[idx], "req_hold", 32'(rd_req), 32'd1);
            rd_ack  = 1'b1;
            rd_data = data;
            @(posedge clk);
            #1 model_capture(idx, data);
            @(negedge clk);
            rd_ack  = 1'b0;
            rd_data = 8'($urandom_range(0, 255));
            chk(rd_req == 1'b0, "req_drop", 32'(rd_req), 32'd0);
        end else begin
            hi = 1;
            for (int c = 1; c < T; c++) begin
                @(negedge clk);
                if (rd_req) hi++;
            end
            chk(hi == T, "req_len", 32'(hi), 32'(T));
            @(posedge clk);
            #1 exp_err = 1'b1;
            @(negedge clk);
            chk(rd_req == 1'b0, "req_drop_tmo", 32'(rd_req), 32'd0);
        end
    endtask

    task automatic run_sweep();
        for (int i = 0; i < 9; i++) serve_read(i, sw_lat[i], sw_data[i], 1'b0);
        @(negedge clk);
        chk(sweep_done == 1'b1, "sweep_done", 32'(sweep_done), 32'd1);
        exp_done++;
    endtask

    task automatic fill_random(input int lat);
        for (int i = 0; i < 9; i++) begin
            sw_data[i] = 8'($urandom_range(0, 255));
            sw_lat[i]  = (lat >= 0) ? lat : int'($urandom_range(0, T - 1));
        end
    endtask

    task automatic spurious_ack();
        rd_ack  = 1'b1;
        rd_data = 8'($urandom_range(0, 255));
        repeat (2) @(negedge clk);
        rd_ack = 1'b0;
        err_valid = 1'b0;
    endtask

    task automatic measure_first_req();
        int n = 0;
        while (!rd_req && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk(n == R + 1, "first_req_latency", 32'(n), 32'(R + 1));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int dc;
        model_reset();
        repeat (3) @(negedge clk);
        chk({seg, min, hora, day, month, year, seg_t, min_t, hora_t} == 72'd0, "reset_regs", 32'(seg), 32'd0);
        chk(rd_req == 1'b0, "reset_rd_req", 32'(rd_req), 32'd0);
        chk(rd_addr == 8'h00, "reset_rd_addr", 32'(rd_addr), 32'd0);
        chk({SF_AM_PM, sweep_done, rd_err} == 3'b000, "reset_flags", 32'({SF_AM_PM, sweep_done, rd_err}), 32'd0);
        cmp_en = 1'b1;
        reset  = 1'b1;
        measure_first_req();

        fill_random(3);
        run_sweep();
        spurious_ack();

        SF_24_12 = 1'b1;
        fill_random(-1);
        sw_data[2] = 8'h31;
        run_sweep();
        chk(hora == 8'h11, "hora_12h", 32'(hora), 32'h11);
        chk(SF_AM_PM == 1'b1, "am_pm_12h", 32'(SF_AM_PM), 32'd1);
        spurious_ack();

        SF_24_12 = 1'b0;
        fill_random(-1);
        sw_data[2] = 8'h23;
        run_sweep();
        chk(hora == 8'h23, "hora_24h", 32'(hora), 32'h23);
        chk(SF_AM_PM == 1'b0, "am_pm_24h", 32'(SF_AM_PM), 32'd0);
        spurious_ack();

        fill_random(-1);
        sw_lat[2] = -1;
        run_sweep();
        chk(rd_err == 1'b1, "timeout_err", 32'(rd_err), 32'd1);
        chk(hora == 8'h23, "timeout_hora_kept", 32'(hora), 32'h23);
        spurious_ack();

        fill_random(-1);
        sw_lat[4] = T - 1;
        run_sweep();
        chk(rd_err == 1'b0, "late_ack_no_err", 32'(rd_err), 32'd0);
        spurious_ack();

        fill_random(-1);
        for (int i = 0; i < 3; i++) serve_read(i, sw_lat[i], sw_data[i], 1'b0);
        serve_read(3, sw_lat[3], sw_data[3], 1'b1);
        err_valid = 1'b0;
        dc = done_cnt;
        hi = 0;
        repeat (3 * R) begin
            @(negedge clk);
            if (rd_req) hi++;
        end
        chk(hi == 0, "abort_no_req", 32'(hi), 32'd0);
        chk(done_cnt == dc, "abort_no_done", 32'(done_cnt), 32'(dc));
        prog_active = 1'b0;
        fill_random(-1);
        run_sweep();
        spurious_ack();

        fill_random(-1);
        hi = 0;
        while (!rd_req && hi < BUDGET) begin
            @(negedge clk);
            hi++;
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk(rd_req == 1'b0, "async_reset_req", 32'(rd_req), 32'd0);
        chk({seg, min, hora, day, month, year, seg_t, min_t, hora_t} == 72'd0, "async_reset_regs", 32'(seg), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        measure_first_req();
        run_sweep();
        spurious_ack();

        for (int s = 0; s < 10; s++) begin
            SF_24_12 = 1'($urandom_range(0, 1));
            fill_random(-1);
            for (int i = 0; i < 9; i++) begin
                if ($urandom_range(0, 7) == 0) sw_lat[i] = -1;
            end
            run_sweep();
            chk(rd_err == logic'(exp_err), "sweep_err", 32'(rd_err), 32'(exp_err));
            spurious_ack();
        end

        chk(done_cnt == exp_done, "done_count", 32'(done_cnt), 32'(exp_done));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
